// File: rtl/obi_data_arbiter.sv
// ----------------------------------------------------------------------------
// obi_data_arbiter
//
// Shares one OBI data slave port (mm_ram data port) between NUM_MASTERS OBI
// masters, e.g. the CV32E40X LSU and the XAVA vector load/store port.
//
// Arbitration is round-robin and purely combinational. Once a request has
// been presented to the slave without a grant, the winner is locked until the
// slave grants it. This keeps the slave-side address/attributes stable, as
// OBI requires. Accepted transactions push the issuing master ID into a small
// FIFO. In-order responses pop it, so each rvalid is routed back to its
// issuer.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   m_req_i/m_gnt_o     per-master request / grant
//   m_addr_i, m_we_i,   packed per-master request attributes
//   m_be_i, m_wdata_i   (master k in slice k of each vector)
//   m_rvalid_o          per-master response valid
//   m_rdata_o           response data, broadcast to all masters
//   s_*                 single slave-side OBI data port
//   err_o               sticky: response seen with nothing outstanding
// ----------------------------------------------------------------------------
module obi_data_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_MASTERS-1:0]               m_req_i,
    output logic [NUM_MASTERS-1:0]               m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_addr_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_wdata_i,
    output logic [NUM_MASTERS-1:0]               m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                m_rdata_o,
    output logic                                 s_req_o,
    input  logic                                 s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic                                 s_we_o,
    output logic [(DATA_WIDTH/8)-1:0]            s_be_o,
    output logic [DATA_WIDTH-1:0]                s_wdata_o,
    input  logic                                 s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                s_rdata_i,
    output logic                                 err_o
);

    localparam int BEW  = DATA_WIDTH / 8;
    localparam int IDW  = $clog2(NUM_MASTERS);
    localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

    // Registers
    logic [IDW-1:0]  r_rr_ptr;
    logic            r_lock;
    logic [IDW-1:0]  r_lock_id;
    logic [IDW-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [CNTW-1:0] r_cnt;
    logic            r_err;

    // Combinational
    logic [IDW-1:0]  w_rr_winner;
    int              w_best;
    logic            w_lock_hit;
    logic [IDW-1:0]  w_winner;
    logic            w_any_req;
    logic            w_room;
    logic            w_sreq;
    logic            w_accept;
    logic            w_pop;
    logic [IDW-1:0]  w_head;
    logic [IDW-1:0]  w_sel;
    logic [IDW-1:0]  w_rr_next;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == PTRW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Round-robin search: the requester with the smallest forward distance
    // from r_rr_ptr wins.
    always_comb begin
        w_rr_winner = '0;
        w_best      = NUM_MASTERS;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (m_req_i[k]) begin
                if (((k + NUM_MASTERS - int'(r_rr_ptr)) % NUM_MASTERS) < w_best) begin
                    w_best      = (k + NUM_MASTERS - int'(r_rr_ptr)) % NUM_MASTERS;
                    w_rr_winner = IDW'(k);
                end
            end
        end
    end

    // A lock only steers arbitration while its master still requests. If the
    // locked master drops out (protocol violation), arbitration falls back to
    // round-robin and the lock is cleared at the next edge.
    assign w_lock_hit = r_lock && m_req_i[r_lock_id];
    assign w_winner   = w_lock_hit ? r_lock_id : w_rr_winner;

    assign w_any_req  = |m_req_i;
    assign w_room     = (r_cnt < CNTW'(MAX_OUTSTANDING));
    assign w_sreq     = !rst_i && w_any_req && w_room;
    assign w_accept   = w_sreq && s_gnt_i;
    // A non-zero count guarantees the FIFO holds the issuer of this response.
    assign w_pop      = !rst_i && s_rvalid_i && (r_cnt != '0);
    assign w_head     = r_fifo[r_rd_ptr];
    // With no request the slave attributes come from master 0.
    assign w_sel      = w_sreq ? w_winner : '0;
    assign w_rr_next  = (w_winner == IDW'(NUM_MASTERS - 1)) ? '0 : w_winner + 1'b1;

    assign s_req_o    = w_sreq;
    assign m_rdata_o  = s_rdata_i;
    assign err_o      = r_err;

    always_comb begin
        s_addr_o   = m_addr_i[0 +: ADDR_WIDTH];
        s_we_o     = m_we_i[0];
        s_be_o     = m_be_i[0 +: BEW];
        s_wdata_o  = m_wdata_i[0 +: DATA_WIDTH];
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (w_sel == IDW'(k)) begin
                s_addr_o  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_we_o    = m_we_i[k];
                s_be_o    = m_be_i[k*BEW +: BEW];
                s_wdata_o = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_accept && (w_winner == IDW'(k))) begin
                m_gnt_o[k] = 1'b1;
            end
            if (w_pop && (w_head == IDW'(k))) begin
                m_rvalid_o[k] = 1'b1;
            end
        end
    end

    // ID storage needs no reset; validity is tracked by r_cnt.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
                r_rr_ptr <= w_rr_next;
                r_lock   <= 1'b0;
            end else if (w_sreq && !r_lock) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_winner;
            end else if (r_lock && !w_lock_hit) begin
                r_lock <= 1'b0;
            end

            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end

            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            if (s_rvalid_i && (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_data_arbiter.sv
module tb_obi_data_arbiter;

    localparam int N  = 2;
    localparam int MO = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_gnt;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_we;
    logic [N*BW-1:0] m_be;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            s_req;
    logic            s_gnt;
    logic [AW-1:0]   s_addr;
    logic            s_we;
    logic [BW-1:0]   s_be;
    logic [DW-1:0]   s_wdata;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic            err;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of outstanding issuer IDs, rr pointer, lock
    int   rr      = 0;
    bit   locked  = 1'b0;
    int   lock_id = 0;
    int   q[$];
    bit   err_m   = 1'b0;

    int           e_win;
    bit           e_sreq;
    bit           e_acc;
    logic [N-1:0] e_gnt = '0;

    obi_data_arbiter #(
        .NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
        .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] req, input logic g,
                         input logic rv, input logic [DW-1:0] rd);
        rst      = r;
        m_req    = req;
        s_gnt    = g;
        s_rvalid = rv;
        s_rdata  = rd;
    endtask

    task automatic set_master(input int k, input logic [AW-1:0] a, input logic w,
                              input logic [BW-1:0] b, input logic [DW-1:0] d);
        m_addr[k*AW +: AW]  = a;
        m_we[k]             = w;
        m_be[k*BW +: BW]    = b;
        m_wdata[k*DW +: DW] = d;
    endtask

    // Compute expected outputs from the model and compare at the falling edge.
    task automatic settle();
        int           sel;
        logic [N-1:0] e_rv;
        @(negedge clk);
        e_win = 0;
        if (locked && m_req[lock_id]) begin
            e_win = lock_id;
        end else begin
            for (int off = N - 1; off >= 0; off--) begin
                if (m_req[(rr + off) % N]) e_win = (rr + off) % N;
            end
        end
        e_sreq = !rst && (m_req != '0) && (q.size() < MO);
        e_acc  = e_sreq && s_gnt;
        e_gnt  = e_acc ? (N'(1) << e_win) : '0;
        e_rv   = '0;
        if (!rst && s_rvalid && q.size() > 0) e_rv = N'(1) << q[0];
        sel = e_sreq ? e_win : 0;
        chk("s_req",    64'(s_req),    64'(e_sreq));
        chk("m_gnt",    64'(m_gnt),    64'(e_gnt));
        chk("m_rvalid", 64'(m_rvalid), 64'(e_rv));
        chk("m_rdata",  64'(m_rdata),  64'(s_rdata));
        chk("err",      64'(err),      64'(err_m));
        chk("s_addr",   64'(s_addr),   64'(m_addr[sel*AW +: AW]));
        chk("s_we",     64'(s_we),     64'(m_we[sel]));
        chk("s_be",     64'(s_be),     64'(m_be[sel*BW +: BW]));
        chk("s_wdata",  64'(s_wdata),  64'(m_wdata[sel*DW +: DW]));
    endtask

    // Advance the model across the rising edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            rr = 0; locked = 1'b0; q.delete(); err_m = 1'b0;
        end else begin
            if (s_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else err_m = 1'b1;
            end
            if (e_acc) begin
                q.push_back(e_win);
                rr = (e_win + 1) % N;
                locked = 1'b0;
            end else if (e_sreq && !locked) begin
                locked = 1'b1;
                lock_id = e_win;
            end else if (locked && !m_req[lock_id]) begin
                locked = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        set_master(0, 32'h100, 1'b0, 4'hF, 32'h1111_1111);
        set_master(1, 32'h200, 1'b1, 4'h3, 32'h2222_2222);

        // Reset: outputs held low even with requests and responses present
        drive(1, 2'b11, 1, 1, 32'h0); settle();
        chk("rst_sreq", 64'(s_req), 64'h0);
        chk("rst_gnt", 64'(m_gnt), 64'h0);
        chk("rst_rvalid", 64'(m_rvalid), 64'h0);
        tick();
        drive(1, 2'b00, 0, 0, 32'h0); settle(); tick();

        // Single master
        drive(0, 2'b01, 1, 0, 32'h0); settle();
        chk("single_gnt", 64'(m_gnt), 64'h1);
        chk("single_addr", 64'(s_addr), 64'h100);
        tick();
        drive(0, 2'b00, 0, 1, 32'hDEAD_BEEF); settle();
        chk("single_rvalid", 64'(m_rvalid), 64'h1);
        chk("single_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
        tick();

        // Round robin: rr now points at M1
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b11, 1, (i > 0), 32'hA0 + i); settle();
            chk("rr_gnt", 64'(m_gnt), (i % 2 == 0) ? 64'h2 : 64'h1);
            chk("rr_rvalid", 64'(m_rvalid), (i == 0) ? 64'h0 : ((i % 2 == 0) ? 64'h1 : 64'h2));
            tick();
        end
        drive(0, 2'b00, 0, 1, 32'hB0); settle();
        chk("rr_last_rvalid", 64'(m_rvalid), 64'h1);
        tick();

        // Move rr back to M0 so the lock is what makes M1 win
        drive(0, 2'b10, 1, 0, 32'h0); settle(); chk("fill_gnt", 64'(m_gnt), 64'h2); tick();
        drive(0, 2'b00, 0, 1, 32'h0); settle(); tick();

        // Lock until grant
        set_master(1, 32'h240, 1'b1, 4'hC, 32'h3333_3333);
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'b10, 0, 0, 32'h0); settle();
            chk("lock_addr_wait", 64'(s_addr), 64'h240);
            chk("lock_gnt_wait", 64'(m_gnt), 64'h0);
            tick();
        end
        set_master(0, 32'h300, 1'b0, 4'h1, 32'h4444_4444);
        drive(0, 2'b11, 0, 0, 32'h0); settle();
        chk("lock_addr_both", 64'(s_addr), 64'h240);
        tick();
        drive(0, 2'b11, 1, 0, 32'h0); settle();
        chk("lock_gnt_m1", 64'(m_gnt), 64'h2);
        chk("lock_addr_m1", 64'(s_addr), 64'h240);
        tick();
        drive(0, 2'b01, 1, 0, 32'h0); settle();
        chk("lock_gnt_m0", 64'(m_gnt), 64'h1);
        chk("lock_addr_m0", 64'(s_addr), 64'h300);
        tick();
        drive(0, 2'b00, 0, 1, 32'h5); settle(); chk("lock_rv_m1", 64'(m_rvalid), 64'h2); tick();
        drive(0, 2'b00, 0, 1, 32'h6); settle(); chk("lock_rv_m0", 64'(m_rvalid), 64'h1); tick();

        // Outstanding limit, then simultaneous push/pop at count 1
        drive(0, 2'b11, 1, 0, 32'h0); settle(); chk("lim_gnt0", 64'(m_gnt), 64'h2); tick();
        drive(0, 2'b11, 1, 0, 32'h0); settle(); chk("lim_gnt1", 64'(m_gnt), 64'h1); tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 2'b11, 1, 0, 32'h0); settle();
            chk("lim_block", 64'(s_req), 64'h0);
            tick();
        end
        drive(0, 2'b11, 1, 1, 32'h7); settle();
        chk("lim_block_rv", 64'(s_req), 64'h0);
        chk("lim_rv_m1", 64'(m_rvalid), 64'h2);
        tick();
        drive(0, 2'b11, 1, 1, 32'h8); settle();
        chk("lim_unblock", 64'(s_req), 64'h1);
        chk("pp_gnt", 64'(m_gnt), 64'h2);
        chk("pp_rv_m0", 64'(m_rvalid), 64'h1);
        tick();
        drive(0, 2'b01, 1, 1, 32'h9); settle();
        chk("pp2_gnt", 64'(m_gnt), 64'h1);
        chk("pp2_rv_head", 64'(m_rvalid), 64'h2);
        tick();
        drive(0, 2'b00, 0, 1, 32'hA); settle(); chk("pp_drain", 64'(m_rvalid), 64'h1); tick();

        // Reset with two outstanding, then a stray response
        drive(0, 2'b11, 1, 0, 32'h0); settle(); tick();
        drive(0, 2'b11, 1, 0, 32'h0); settle(); tick();
        drive(1, 2'b00, 0, 1, 32'h0); settle(); chk("rst_drop_rv", 64'(m_rvalid), 64'h0); tick();
        drive(0, 2'b00, 0, 1, 32'h0); settle();
        chk("stray_rv", 64'(m_rvalid), 64'h0);
        chk("err_not_yet", 64'(err), 64'h0);
        tick();
        drive(0, 2'b00, 0, 0, 32'h0); settle(); chk("err_set", 64'(err), 64'h1); tick();
        drive(1, 2'b00, 0, 0, 32'h0); settle(); chk("err_in_rst", 64'(err), 64'h1); tick();
        drive(0, 2'b00, 0, 0, 32'h0); settle(); chk("err_clr", 64'(err), 64'h0); tick();

        // Randomized traffic obeying OBI: requests held until granted, ordered responses
        for (int it = 0; it < 500; it++) begin
            for (int k = 0; k < N; k++) begin
                if (!(m_req[k] && !e_gnt[k])) begin
                    m_req[k] = ($urandom_range(0, 2) != 0);
                    set_master(k, $urandom, 1'($urandom_range(0, 1)),
                               4'($urandom_range(0, 15)), $urandom);
                end
            end
            rst      = 1'b0;
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            settle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obi_data_arbiter.md
Name: obi_data_arbiter

Overview:
- Parameterised N-master to 1-slave OBI data-bus arbiter that shares the single RAM data port between the CV32E40X LSU and the XAVA vector unit's load/store port.
- Implements round-robin grant with lock-until-grant, so slave-side attributes stay stable.
- Tracks outstanding transactions in an ID FIFO, so each response is routed back to the master that issued it.
- Sits between the masters' OBI data ports and mm_ram's data port in the TB wrapper.

Parameters:
NUM_MASTERS, 2, number of OBI masters (>=2)
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (>=1; also ID FIFO depth)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (byte-enable width = DATA_WIDTH/8)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
m_req_i  in  NUM_MASTERS  per-master request
m_gnt_o  out  NUM_MASTERS  per-master grant
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
m_we_i  in  NUM_MASTERS  write enables
m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  packed byte enables
m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_rvalid_o  out  NUM_MASTERS  per-master response valid
m_rdata_o  out  DATA_WIDTH  read data, broadcast to all masters; qualified by m_rvalid_o
s_req_o  out  1  slave request
s_gnt_i  in  1  slave grant
s_addr_o  out  ADDR_WIDTH  slave address
s_we_o  out  1  slave write enable
s_be_o  out  DATA_WIDTH/8  slave byte enable
s_wdata_o  out  DATA_WIDTH  slave write data
s_rvalid_i  in  1  slave response valid
s_rdata_i  in  DATA_WIDTH  slave read data
err_o  out  1  sticky protocol error: response arrived with no transaction outstanding

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- State:
  - rr_ptr: round-robin pointer, clog2(NUM_MASTERS) bits.
  - lock_q / lock_id_q: grant-lock flag and locked master ID.
  - ID FIFO: MAX_OUTSTANDING entries with rd/wr pointers.
  - cnt_q: outstanding count, clog2(MAX_OUTSTANDING+1) bits.
  - err_q: sticky error flag.
- Reset, while rst_i=1 in the sampled cycle:
  - Next state: rr_ptr=0, lock_q=0, FIFO empty, cnt_q=0, err_q=0.
  - Outputs forced combinationally: s_req_o=0, m_gnt_o=0, m_rvalid_o=0.
  - Responses arriving during reset are dropped.
- Arbitration is combinational, with zero added request latency.
  - If lock_q=1, the winner is lock_id_q.
  - Otherwise the winner is the first k with m_req_i[k]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_MASTERS.
- Request and grant:
  - s_req_o = any m_req_i && cnt_q < MAX_OUTSTANDING.
  - s_addr_o/s_we_o/s_be_o/s_wdata_o = winner's fields. When s_req_o=0 these outputs are don't-care, but must be driven from master 0's fields.
  - m_gnt_o[winner] = s_req_o && s_gnt_i; all other m_gnt_o bits are 0.
- Handshake accept (s_req_o && s_gnt_i):
  - Push winner ID into the FIFO.
  - rr_ptr <= (winner+1) mod NUM_MASTERS.
  - lock_q <= 0.
- Lock:
  - Set when s_req_o=1 && s_gnt_i=0 && lock_q=0: lock_q<=1, lock_id_q<=winner.
  - Held until that master is granted, so slave attributes stay stable per OBI.
  - Masters must not drop m_req_i before m_gnt_o; if the locked master drops it anyway, the lock clears next cycle and err_q is not set.
- Outstanding limit:
  - cnt_q == MAX_OUTSTANDING forces s_req_o=0.
  - An s_rvalid_i in the same cycle does not unblock; the new request is issued the next cycle.
- Response:
  - When s_rvalid_i=1 and the FIFO is non-empty: m_rvalid_o[fifo_head]=1 in the same cycle, then pop.
  - m_rdata_o = s_rdata_i at all times.
- Count update: accept-only gives cnt+1; rvalid-only gives cnt-1; both in the same cycle leave cnt unchanged (push and pop both performed).
- Error: s_rvalid_i=1 with cnt_q=0 sets err_q=1 and drives no m_rvalid_o. err_q clears only on reset. err_o = err_q.
- Ordering: the slave returns responses in order, and the FIFO relies on it. Responses may arrive in the same cycle as grant+1 or later; a 0-cycle response is not supported.

Test Plan:
- Single master: m_req_i=2'b01, addr 0x100, s_gnt_i=1, s_rvalid_i one cycle later with rdata 0xDEADBEEF → m_gnt_o=01 in cycle 0, m_rvalid_o=01 in cycle 1, m_rdata_o=0xDEADBEEF, rr_ptr=1.
- Round-robin fairness: both masters request continuously, s_gnt_i=1, rvalid 1 cycle later → grants alternate M0, M1, M0, M1; each master receives exactly its own rvalid, in order.
- Lock-until-grant: M1 requests alone, s_gnt_i=0 for 3 cycles, then M0 also requests, then s_gnt_i=1 → s_addr_o holds M1's address every cycle, M1 is granted first, then M0 next.
- Outstanding limit: MAX_OUTSTANDING=2, rvalid withheld → after 2 grants s_req_o=0. First rvalid in cycle t → s_req_o=1 in cycle t+1; routing stays M0 then M1 per issue order.
- Simultaneous push/pop at cnt_q=1: accept and rvalid in the same cycle → cnt_q stays 1, and the FIFO head advances to the new entry.
- Reset and error: assert rst_i with 2 outstanding, then deassert and drive s_rvalid_i=1 → m_rvalid_o=0, err_o=1 from the next cycle; rst_i again → err_o=0.
